// File: rtl/otp_prog_seq.sv
// otp_prog_seq: command sequencer in front of the generic OTP macro.
// Turns each program request into pre-read, blank check, masked write and
// verify read-back; read requests are a single macro read. One response
// per request carries the data word and an error code.
// Optional feature macro: OTP_PROG_RETRY_EN (bounded write+verify retries).
module otp_prog_seq #(
  parameter int Width         = 8,
  parameter int Depth         = 1024,
  parameter int TimeoutCycles = 64,
  parameter int MaxRetries    = 2,
  localparam int AddrWidth    = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_prog_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [Width-1:0]     req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [Width-1:0]     rsp_rdata_o,
  output logic [1:0]           rsp_err_o,
  input  logic                 otp_ready_i,
  output logic                 otp_valid_o,
  output logic [AddrWidth-1:0] otp_addr_o,
  output logic [Width-1:0]     otp_wdata_o,
  output logic                 otp_wren_o,
  input  logic [Width-1:0]     otp_rdata_i,
  input  logic                 otp_rvalid_i
);

  localparam int TmoW = $clog2(TimeoutCycles + 1);

  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrClear   = 2'd1;
  localparam logic [1:0] ErrVerify  = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  if (TimeoutCycles < 1 || MaxRetries < 0) begin : g_badParam
    $error("otp_prog_seq: TimeoutCycles must be >= 1 and MaxRetries >= 0");
  end

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, VF_REQ, VF_WAIT, RESP
  } state_e;

  state_e               r_state;
  state_e               w_stateNext;
  logic                 r_prog;
  logic [AddrWidth-1:0] r_addr;
  logic [Width-1:0]     r_wdata;
  logic [Width-1:0]     r_rdata;
  logic [Width-1:0]     w_rdataNext;
  logic [1:0]           r_err;
  logic [1:0]           w_errNext;
  logic [TmoW-1:0]      r_tmoCnt;
  logic                 w_tmoHit;
  logic                 w_accept;
  logic                 w_waiting;

`ifdef OTP_PROG_RETRY_EN
  localparam int RetryW = (MaxRetries < 1) ? 1 : $clog2(MaxRetries + 1);
  logic [RetryW-1:0]    r_retryCnt;
  logic                 w_retryInc;
`endif

  assign w_accept    = (r_state == IDLE) && req_valid_i;
  assign w_waiting   = (r_state == RD_WAIT) || (r_state == VF_WAIT);
  assign w_tmoHit    = (r_tmoCnt == TmoW'(TimeoutCycles - 1));
  assign otp_addr_o  = r_addr;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

  // State register and datapath capture: request fields, last read word, error code, wait counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_prog   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= ErrOk;
      r_tmoCnt <= '0;
    end else begin
      r_state <= w_stateNext;
      r_rdata <= w_rdataNext;
      r_err   <= w_errNext;
      if (w_accept) begin
        r_prog  <= req_prog_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
      end
      if (w_waiting && (w_stateNext == r_state)) begin
        r_tmoCnt <= r_tmoCnt + 1'b1;
      end else begin
        r_tmoCnt <= '0;
      end
    end
  end

`ifdef OTP_PROG_RETRY_EN
  // Retry counter: cleared per request, bumped on each re-write after a verify miss
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_retryCnt <= '0;
    end else if (w_accept) begin
      r_retryCnt <= '0;
    end else if (w_retryInc) begin
      r_retryCnt <= r_retryCnt + 1'b1;
    end
  end
`endif

  // Next-state, macro command and response handshake decode
  always_comb begin
    w_stateNext = r_state;
    w_rdataNext = r_rdata;
    w_errNext   = r_err;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    otp_valid_o = 1'b0;
    otp_wren_o  = 1'b0;
    otp_wdata_o = '0;
`ifdef OTP_PROG_RETRY_EN
    w_retryInc  = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_rdataNext = '0;
          w_errNext   = ErrOk;
          w_stateNext = RD_REQ;
        end
      end
      RD_REQ: begin
        otp_valid_o = 1'b1;
        if (otp_ready_i) w_stateNext = RD_WAIT;
      end
      RD_WAIT: begin
        if (otp_rvalid_i) begin
          w_rdataNext = otp_rdata_i;
          if (r_prog) begin
            w_stateNext = CHECK;
          end else begin
            w_errNext   = ErrOk;
            w_stateNext = RESP;
          end
        end else if (w_tmoHit) begin
          w_rdataNext = '0;
          w_errNext   = ErrTimeout;
          w_stateNext = RESP;
        end
      end
      CHECK: begin
        if ((r_rdata & ~r_wdata) != '0) begin
          w_errNext   = ErrClear;
          w_stateNext = RESP;
        end else if (r_rdata == r_wdata) begin
          w_errNext   = ErrOk;
          w_stateNext = RESP;
        end else begin
          w_stateNext = WR_REQ;
        end
      end
      WR_REQ: begin
        otp_valid_o = 1'b1;
        otp_wren_o  = 1'b1;
        otp_wdata_o = r_wdata & ~r_rdata;
        if (otp_ready_i) w_stateNext = VF_REQ;
      end
      VF_REQ: begin
        otp_valid_o = 1'b1;
        if (otp_ready_i) w_stateNext = VF_WAIT;
      end
      VF_WAIT: begin
        if (otp_rvalid_i) begin
          w_rdataNext = otp_rdata_i;
          if (otp_rdata_i == r_wdata) begin
            w_errNext   = ErrOk;
            w_stateNext = RESP;
          end else begin
`ifdef OTP_PROG_RETRY_EN
            if ((otp_rdata_i & ~r_wdata) != '0) begin
              w_errNext   = ErrClear;
              w_stateNext = RESP;
            end else if (int'(r_retryCnt) < MaxRetries) begin
              w_retryInc  = 1'b1;
              w_stateNext = WR_REQ;
            end else begin
              w_errNext   = ErrVerify;
              w_stateNext = RESP;
            end
`else
            w_errNext   = ErrVerify;
            w_stateNext = RESP;
`endif
          end
        end else if (w_tmoHit) begin
          w_rdataNext = '0;
          w_errNext   = ErrTimeout;
          w_stateNext = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

endmodule
